// File: rtl/updown_seq_ctrl_pkg.sv
// updown_seq_ctrl_pkg: shared FSM states, datapath ops and default sizes
package updown_seq_ctrl_pkg;
  localparam int W_DEF = 3;
  localparam int NREQ_DEF = 2;
  typedef enum logic [2:0] {IDLE, UP, DOWN, REP, DONE} state_t;
  localparam logic [1:0] OP_HOLD = 2'd0, OP_LOAD = 2'd1, OP_INC = 2'd2, OP_DEC = 2'd3;
endpackage

// File: rtl/updown_cnt_dp.sv
// updown_cnt_dp: W-bit counter with load/inc/dec/hold, modulo 2^W
module updown_cnt_dp
  import updown_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   op,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else q <= op == OP_LOAD ? d : op == OP_INC ? q + W'(1) : op == OP_DEC ? q - W'(1) : q;
endmodule

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: round-robin arbitrated up/down sequence generator with repeat value
module updown_seq_ctrl
  import updown_seq_ctrl_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] cfg_lo,
  input  logic [NREQ*W-1:0] cfg_hi,
  input  logic [NREQ*W-1:0] cfg_rep,
  input  logic [2*NREQ-1:0] cfg_cyc,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      cnt,
  output logic              cnt_vld,
  output logic              owner,
  output logic              busy,
  output logic [NREQ-1:0]   done
);
  state_t state, nxt;
  logic [W-1:0] lo_q, hi_q, rep_q, lo_in, hi_in, rep_in, cnt_inc, cnt_dec;
  logic [1:0] rem, cyc_in, op;
  logic last, sel, take, rep_en, at_lo, up_hit;
  assign sel = &req ? ~last : req[1];
  assign take = rst && state == IDLE && |req;
  assign lo_in = sel ? cfg_lo[2*W-1:W] : cfg_lo[W-1:0];
  assign hi_in = sel ? cfg_hi[2*W-1:W] : cfg_hi[W-1:0];
  assign rep_in = sel ? cfg_rep[2*W-1:W] : cfg_rep[W-1:0];
  assign cyc_in = sel ? cfg_cyc[3:2] : cfg_cyc[1:0];
  assign cnt_inc = cnt + W'(1);
  assign cnt_dec = cnt - W'(1);
  assign rep_en = lo_q < rep_q && rep_q < hi_q;
  assign at_lo = cnt == lo_q;
  assign up_hit = cnt_inc == hi_q;

  updown_cnt_dp #(.W(W)) u_dp (.clk(clk), .rst(rst), .op(op), .d(lo_in), .q(cnt));

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= nxt;

  // last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk)
    if (!rst) begin
      last <= 1'b1;
      owner <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      rep_q <= '0;
      rem <= '0;
    end else if (take) begin
      last <= sel;
      owner <= sel;
      lo_q <= lo_in;
      hi_q <= hi_in;
      rep_q <= rep_in;
      rem <= cyc_in;
    end else if (state == DOWN && at_lo && rem != 2'd0)
      rem <= rem - 2'd1;

  // a new pass starts at lo+1, which may already be hi when hi==lo+1
  always_comb begin
    nxt = state;
    op = OP_HOLD;
    case (state)
      IDLE: begin
        nxt = take ? UP : IDLE;
        op = take ? OP_LOAD : OP_HOLD;
      end
      UP: begin
        nxt = lo_q >= hi_q ? DONE : up_hit ? DOWN : UP;
        op = lo_q >= hi_q ? OP_HOLD : OP_INC;
      end
      DOWN:
        if (at_lo) begin
          nxt = rem == 2'd0 ? DONE : up_hit ? DOWN : UP;
          op = rem == 2'd0 ? OP_HOLD : OP_INC;
        end else begin
          nxt = rep_en && cnt_dec == rep_q ? REP : DOWN;
          op = OP_DEC;
        end
      REP: nxt = DOWN;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = take ? (sel ? 2'b10 : 2'b01) : '0;
    busy = state != IDLE;
    cnt_vld = state inside {UP, DOWN, REP};
    done = state == DONE ? (owner ? 2'b10 : 2'b01) : '0;
  end
endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb_updown_seq_ctrl: scoreboard bench with a sequence-list reference model
module tb_updown_seq_ctrl;
  localparam int W = 3;
  logic clk = 0;
  logic rst = 0;
  logic [1:0] req = 0;
  logic [2*W-1:0] cfg_lo = 0, cfg_hi = 0, cfg_rep = 0;
  logic [3:0] cfg_cyc = 0;
  logic [1:0] gnt, done;
  logic [W-1:0] cnt;
  logic cnt_vld, owner, busy;
  int errors = 0, checks = 0;
  int exp_cnt[$];
  int exp_done[$];
  int last_m = 1;

  updown_seq_ctrl #(.W(W), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .cfg_rep(cfg_rep), .cfg_cyc(cfg_cyc), .gnt(gnt), .cnt(cnt),
    .cnt_vld(cnt_vld), .owner(owner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int i, input int lo, input int hi, input int rep, input int cyc);
    cfg_lo[i*W +: W] = W'(lo);
    cfg_hi[i*W +: W] = W'(hi);
    cfg_rep[i*W +: W] = W'(rep);
    cfg_cyc[i*2 +: 2] = 2'(cyc);
  endtask

  // expected samples: lo..hi up, hi-1..lo down, rep doubled when strictly inside
  task automatic push_model(input int win);
    int lo, hi, rep, cyc;
    lo = int'(cfg_lo[win*W +: W]);
    hi = int'(cfg_hi[win*W +: W]);
    rep = int'(cfg_rep[win*W +: W]);
    cyc = int'(cfg_cyc[win*2 +: 2]);
    if (lo >= hi) exp_cnt.push_back(win*256 + lo);
    else
      for (int p = 0; p <= cyc; p++) begin
        for (int v = (p == 0 ? lo : lo + 1); v <= hi; v++) exp_cnt.push_back(win*256 + v);
        for (int v = hi - 1; v >= lo; v--) begin
          exp_cnt.push_back(win*256 + v);
          if (v == rep && rep > lo) exp_cnt.push_back(win*256 + v);
        end
      end
    exp_done.push_back(win);
  endtask

  task automatic take_grant(input bit drop);
    int t, win;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt == 2'b00 && t < 300);
    if (gnt == 2'b00) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    win = (req == 2'b11) ? (last_m == 1 ? 0 : 1) : (req[1] ? 1 : 0);
    check("gnt", gnt, 1 << win);
    check("busy_at_gnt", busy, 0);
    last_m = win;
    push_model(win);
    @(posedge clk);
    #1;
    if (drop) req[win] = 1'b0;
    set_cfg(win, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
  endtask

  task automatic serve(input logic [1:0] r);
    @(posedge clk);
    #1 req = r;
    for (int k = 0; k < $countones(r); k++) take_grant(1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_cnt.size() != 0 || exp_done.size() != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_cnt.size() + exp_done.size(), 0);
  endtask

  always @(negedge clk)
    if (rst) begin
      if (cnt_vld) begin
        if (exp_cnt.size() == 0) check("cnt_unexpected", cnt, 999);
        else begin
          int e;
          e = exp_cnt.pop_front();
          check("cnt", cnt, e % 256);
          check("owner", owner, e / 256);
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0 || exp_cnt.size() != 0) check("done_early", done, 0);
        else begin
          int e;
          e = exp_done.pop_front();
          check("done", done, 1 << e);
          check("done_owner", owner, e);
        end
      end
    end

  initial begin
    req = 2'b11;
    set_cfg(0, 2, 4, 3, 0);
    set_cfg(1, 2, 4, 3, 0);
    repeat (2) @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_vld", cnt_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_owner", owner, 0);
    @(posedge clk);
    #1 rst = 1;
    take_grant(1);
    take_grant(1);
    set_cfg(0, 1, 6, 4, 0);
    serve(2'b01);
    set_cfg(1, 0, 2, 7, 1);
    serve(2'b10);
    set_cfg(0, 5, 5, 2, 2);
    serve(2'b01);
    set_cfg(1, 6, 3, 4, 3);
    serve(2'b10);
    set_cfg(0, 3, 4, 3, 3);
    serve(2'b01);
    drain();
    set_cfg(0, 1, 6, 4, 0);
    @(posedge clk);
    #1 req = 2'b01;
    take_grant(0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    exp_cnt.delete();
    exp_done.delete();
    last_m = 1;
    @(negedge clk);
    check("abort_cnt", cnt, 0);
    check("abort_vld", cnt_vld, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk);
    #1 rst = 1;
    set_cfg(0, 0, 3, 1, 1);
    take_grant(1);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        set_cfg(i, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      serve(2'($urandom_range(1, 3)));
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
